// File: rtl/decodificador_quadro_dht.sv
// rtl/decodificador_quadro_dht.sv - DHT frame decoder: checksum/range check, optional BCD conversion, publish
// Optional BCD path (CONVERTE_U/CONVERTE_T states) enabled by defining DECODIFICADOR_BCD_EN.
module decodificador_quadro_dht #(
  parameter int UMIDADE_MAX = 1000,
  parameter int TEMP_MAX    = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] dados_brutos,
  input  logic        leitura_concluida,
  output logic [9:0]  umidade_x10,
  output logic [10:0] temperatura_x10,
  output logic        temperatura_negativa,
  output logic [15:0] umidade_bcd,
  output logic [11:0] temperatura_bcd,
  output logic        dado_valido,
  output logic        erro_checksum,
  output logic        erro_faixa,
  output logic [7:0]  contador_erros
);
  typedef enum logic [2:0] {OCIOSO, VERIFICA, CONVERTE_U, CONVERTE_T, PUBLICA} estado_t;
  estado_t estado, proximo;

  logic [39:0] quadro;
  logic        leitura_ant, armado, borda;
  logic [7:0]  soma;
  logic        erro_cs, erro_fx, fim_conv, negativo;
  logic [15:0] umidade_bruta;
  logic [14:0] temp_mag;
  logic [10:0] mag11;

  // armado stays low after reset until the input has been seen low once
  assign borda         = leitura_concluida && !leitura_ant && armado;
  assign umidade_bruta = quadro[39:24];
  assign temp_mag      = quadro[22:8];
  assign soma          = quadro[39:32] + quadro[31:24] + quadro[23:16] + quadro[15:8];
  assign erro_cs       = (soma != quadro[7:0]) || (quadro == 40'd0);
  assign erro_fx       = (32'(umidade_bruta) > UMIDADE_MAX) || (32'(temp_mag) > TEMP_MAX);
  assign mag11         = {1'b0, temp_mag[9:0]};
  assign negativo      = quadro[23] && (temp_mag != 15'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leitura_ant <= 1'b0;
      armado      <= 1'b0;
    end else begin
      leitura_ant <= leitura_concluida;
      if (!leitura_concluida) armado <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:     if (borda) proximo = VERIFICA;
      VERIFICA: begin
        if (erro_cs || erro_fx) proximo = OCIOSO;
`ifdef DECODIFICADOR_BCD_EN
        else                    proximo = CONVERTE_U;
`else
        else                    proximo = PUBLICA;
`endif
      end
      CONVERTE_U: if (fim_conv) proximo = CONVERTE_T;
      CONVERTE_T: if (fim_conv) proximo = PUBLICA;
      PUBLICA:    proximo = OCIOSO;
      default:    proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quadro               <= 40'd0;
      umidade_x10          <= 10'd0;
      temperatura_x10      <= 11'd0;
      temperatura_negativa <= 1'b0;
      dado_valido          <= 1'b0;
      erro_checksum        <= 1'b0;
      erro_faixa           <= 1'b0;
      contador_erros       <= 8'd0;
    end else begin
      dado_valido   <= 1'b0;
      erro_checksum <= 1'b0;
      erro_faixa    <= 1'b0;
      if (estado == OCIOSO && borda) quadro <= dados_brutos;
      if (estado == VERIFICA && (erro_cs || erro_fx)) begin
        erro_checksum <= erro_cs;
        erro_faixa    <= !erro_cs;
        if (contador_erros != 8'hFF) contador_erros <= contador_erros + 8'd1;
      end
      if (estado == PUBLICA) begin
        dado_valido          <= 1'b1;
        umidade_x10          <= umidade_bruta[9:0];
        temperatura_x10      <= negativo ? (11'd0 - mag11) : mag11;
        temperatura_negativa <= negativo;
      end
    end
  end

`ifdef DECODIFICADOR_BCD_EN
  // Double-dabble, one bit per cycle; values stay below 1024 so digit 3 is at most 1
  logic [11:0] acc, acc_aj;
  logic [12:0] acc_prox;
  logic [9:0]  bin;
  logic [3:0]  cnt;
  logic [15:0] bcd_u_res;
  logic [11:0] bcd_t_res;

  always_comb begin
    acc_aj = acc;
    for (int d = 0; d < 3; d++)
      if (acc[4*d +: 4] >= 4'd5) acc_aj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    acc_prox = {acc_aj, bin[9]};
  end

  assign fim_conv = (cnt == 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= 12'd0;
      bin             <= 10'd0;
      cnt             <= 4'd0;
      bcd_u_res       <= 16'd0;
      bcd_t_res       <= 12'd0;
      umidade_bcd     <= 16'd0;
      temperatura_bcd <= 12'd0;
    end else begin
      case (estado)
        VERIFICA: begin
          acc <= 12'd0;
          bin <= umidade_bruta[9:0];
          cnt <= 4'd0;
        end
        CONVERTE_U: begin
          if (fim_conv) begin
            bcd_u_res <= {3'd0, acc_prox};
            acc       <= 12'd0;
            bin       <= temp_mag[9:0];
            cnt       <= 4'd0;
          end else begin
            acc <= acc_prox[11:0];
            bin <= {bin[8:0], 1'b0};
            cnt <= cnt + 4'd1;
          end
        end
        CONVERTE_T: begin
          if (fim_conv) begin
            bcd_t_res <= acc_prox[11:0];
          end else begin
            acc <= acc_prox[11:0];
            bin <= {bin[8:0], 1'b0};
            cnt <= cnt + 4'd1;
          end
        end
        PUBLICA: begin
          umidade_bcd     <= bcd_u_res;
          temperatura_bcd <= bcd_t_res;
        end
        default: ;
      endcase
    end
  end
`else
  assign fim_conv        = 1'b0;
  assign umidade_bcd     = 16'd0;
  assign temperatura_bcd = 12'd0;
`endif

endmodule

// File: doc/decodificador_quadro_dht.md
DECODIFICADOR_QUADRO_DHT -- requirements
Module: decodificador_quadro_dht

Interface
REQ-001 The block SHALL have parameter UMIDADE_MAX, default 1000, the maximum accepted humidity in 0.1 %RH.
REQ-002 The block SHALL have parameter TEMP_MAX, default 800, the maximum accepted temperature magnitude in 0.1 degC.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dados_brutos  input  40  sensor frame: [39:24] humidity, [23:8] temperature (bit 23 = sign), [7:0] checksum.
REQ-006 leitura_concluida  input  1  level from the sensor reader; may stay high for many cycles; only its rising edge marks a new frame.
REQ-007 umidade_x10  output  10  last accepted humidity, unsigned, in 0.1 %RH.
REQ-008 temperatura_x10  output  11  last accepted temperature, two's complement, in 0.1 degC.
REQ-009 temperatura_negativa  output  1  sign of the last accepted temperature.
REQ-010 umidade_bcd  output  16  four BCD digits of umidade_x10.
REQ-011 temperatura_bcd  output  12  three BCD digits of the temperature magnitude.
REQ-012 dado_valido  output  1  one-cycle pulse when new values are published.
REQ-013 erro_checksum  output  1  one-cycle pulse on checksum failure or an all-zero frame.
REQ-014 erro_faixa  output  1  one-cycle pulse on an out-of-range value.
REQ-015 contador_erros  output  8  count of rejected frames; saturates at 255.

Function
REQ-016 Edge detect: the edge SHALL be leitura_concluida=1 while its registered previous value is 0; the cycle in which this holds is cycle k.
REQ-017 FSM states: OCIOSO, VERIFICA, CONVERTE_U, CONVERTE_T, PUBLICA.
REQ-018 In OCIOSO at cycle k, the block SHALL capture dados_brutos into an internal frame register and enter VERIFICA.
REQ-019 Edges occurring outside OCIOSO SHALL be ignored; no output changes and no error is flagged.
REQ-020 Checksum: the modulo-256 sum of bytes [39:32], [31:24], [23:16] and [15:8] SHALL equal [7:0]; on mismatch, or when all 40 bits are 0, the block SHALL assert erro_checksum in cycle k+2 and return to OCIOSO.
REQ-021 Range: if humidity > UMIDADE_MAX or temperature magnitude ([22:8]) > TEMP_MAX, the block SHALL assert erro_faixa in cycle k+2 and return to OCIOSO; checksum failure takes priority.
REQ-022 A rejected frame SHALL leave every value output unchanged and SHALL increment contador_erros (saturating).
REQ-023 Conversion: the block SHALL use iterative double-dabble, 1 bit per cycle. CONVERTE_U SHALL take 10 cycles (k+2..k+11); CONVERTE_T SHALL take 10 cycles on the 10-bit magnitude (k+12..k+21); PUBLICA SHALL occur at k+22.
REQ-024 PUBLICA SHALL update all value outputs atomically; dado_valido SHALL be high in cycle k+23 only, then the FSM SHALL return to OCIOSO.
REQ-025 Negative zero (sign=1, magnitude 0) SHALL publish temperatura_x10=0 and temperatura_negativa=0.
REQ-026 The block SHALL set temperatura_x10 = magnitude when sign=0, and -magnitude (11-bit two's complement) when sign=1.

Reset
REQ-027 reset=0 SHALL immediately force OCIOSO and set every output, the frame register, the edge register and contador_erros to 0, including during conversion.
REQ-028 After reset release, leitura_concluida already high SHALL NOT count as an edge until it has been sampled low.

Configuration
REQ-029 Macro DECODIFICADOR_BCD_EN: when defined, the BCD conversion and states CONVERTE_U/CONVERTE_T SHALL be present and latency SHALL be as in REQ-023/024.
REQ-030 When DECODIFICADOR_BCD_EN is undefined, the BCD outputs SHALL be tied to 0, VERIFICA SHALL go directly to PUBLICA at k+2, and dado_valido SHALL be high in cycle k+3; ports SHALL be unchanged.

Verification
REQ-031 Frame 0x028C015FEE, edge -> dado_valido at k+23; umidade_x10=652, umidade_bcd=0x0652, temperatura_x10=351, temperatura_bcd=0x351, temperatura_negativa=0.
REQ-032 Frame 0x028C806573 -> temperatura_x10=-101 (0x79B), temperatura_negativa=1, temperatura_bcd=0x101.
REQ-033 Frame 0x028C015FEF -> erro_checksum at k+2, contador_erros=1, outputs keep values from REQ-031; frame 0x0000000000 -> erro_checksum.
REQ-034 Frame 0x03E90000EC (humidity 1001) -> erro_faixa at k+2, no dado_valido.
REQ-035 Second edge at k+5 during conversion -> ignored, single dado_valido; reset=0 at k+8 -> all outputs 0, no dado_valido.
REQ-036 Hold leitura_concluida high for 1250 cycles -> exactly one frame processed; 300 bad frames -> contador_erros=255.
